// File: rtl/hqm_aw_sync_deglitch.sv
// -----------------------------------------------------------------------------
// hqm_aw_sync_deglitch
//
// Deglitch and edge-detect stage that sits directly behind a single-bit
// double-flop synchronizer. A change on the synchronized level is accepted
// only after it has differed from the current filtered level for
// FILTER_CYCLES consecutive enabled clocks. Accepted changes produce a
// one-cycle rise or fall pulse and bump a saturating transition counter that
// is exposed to status/debug CSRs.
//
// Parameters:
//   FILTER_CYCLES  consecutive differing samples needed to accept a change (1..255)
//   RST_VAL        reset value of the filtered level
//   CNT_WIDTH      width of the transition counter (1..32)
//
// Ports:
//   clk           clock, single domain
//   rst_n         synchronous active-low reset
//   data_sync     synchronized input level
//   enable        filter enable; low freezes the filter and clears progress
//   cnt_clr       synchronous clear of edge_cnt / edge_cnt_sat
//   data_filt     filtered level (registered)
//   rise          one-cycle pulse on an accepted 0->1 change (registered)
//   fall          one-cycle pulse on an accepted 1->0 change (registered)
//   edge_cnt      saturating count of accepted transitions (registered)
//   edge_cnt_sat  sticky flag, set once edge_cnt reaches all-ones (registered)
// -----------------------------------------------------------------------------
module hqm_aw_sync_deglitch #(
    parameter int       FILTER_CYCLES = 4,
    parameter logic     RST_VAL       = 1'b0,
    parameter int       CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_sync,
    input  logic                 enable,
    input  logic                 cnt_clr,
    output logic                 data_filt,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] edge_cnt,
    output logic                 edge_cnt_sat
);

    localparam int                STAB_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_CYCLES - 1);

    logic [STAB_W-1:0]    r_stab_cnt;
    logic                 r_data_filt;
    logic                 r_rise;
    logic                 r_fall;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic                 r_edge_cnt_sat;

    logic                 w_differ;
    logic                 w_accept;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    // A change is accepted on the edge that sees the last of FILTER_CYCLES
    // consecutive differing samples.
    assign w_differ  = (data_sync != r_data_filt);
    assign w_accept  = enable && w_differ && (r_stab_cnt == STAB_LAST);
    assign w_cnt_inc = r_edge_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stab_cnt     <= '0;
            r_data_filt    <= RST_VAL;
            r_rise         <= 1'b0;
            r_fall         <= 1'b0;
            r_edge_cnt     <= '0;
            r_edge_cnt_sat <= 1'b0;
        end else begin
            // Pulses are single-cycle: default low, raised only on acceptance.
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            if (!enable) begin
                r_stab_cnt <= '0;
            end else if (!w_differ) begin
                r_stab_cnt <= '0;
            end else if (w_accept) begin
                r_data_filt <= data_sync;
                r_stab_cnt  <= '0;
                r_rise      <= data_sync;
                r_fall      <= ~data_sync;
            end else begin
                r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            end

            // Clear coinciding with an accepted transition keeps that event.
            if (cnt_clr) begin
                r_edge_cnt     <= w_accept ? CNT_WIDTH'(1) : '0;
                r_edge_cnt_sat <= 1'b0;
            end else if (w_accept && (r_edge_cnt != '1)) begin
                r_edge_cnt <= w_cnt_inc;
                if (w_cnt_inc == '1) begin
                    r_edge_cnt_sat <= 1'b1;
                end
            end
        end
    end

    assign data_filt    = r_data_filt;
    assign rise         = r_rise;
    assign fall         = r_fall;
    assign edge_cnt     = r_edge_cnt;
    assign edge_cnt_sat = r_edge_cnt_sat;

endmodule

// File: tb/tb_hqm_aw_sync_deglitch.sv
// -----------------------------------------------------------------------------
// tb_hqm_aw_sync_deglitch
//
// Directed bench for hqm_aw_sync_deglitch. Instance A uses FILTER_CYCLES=4,
// CNT_WIDTH=8; instance B uses FILTER_CYCLES=1, CNT_WIDTH=2. Inputs are
// driven 1 time unit after each rising edge; outputs are compared at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_hqm_aw_sync_deglitch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (N=4)
    logic       a_rst_n, a_ds, a_en, a_clr;
    logic       a_filt, a_rise, a_fall, a_sat;
    logic [7:0] a_cnt;

    // Instance B (N=1, 2-bit counter)
    logic       b_rst_n, b_ds, b_en, b_clr;
    logic       b_filt, b_rise, b_fall, b_sat;
    logic [1:0] b_cnt;

    hqm_aw_sync_deglitch #(.FILTER_CYCLES(4), .RST_VAL(1'b0), .CNT_WIDTH(8)) u_dut_a (
        .clk          (clk),
        .rst_n        (a_rst_n),
        .data_sync    (a_ds),
        .enable       (a_en),
        .cnt_clr      (a_clr),
        .data_filt    (a_filt),
        .rise         (a_rise),
        .fall         (a_fall),
        .edge_cnt     (a_cnt),
        .edge_cnt_sat (a_sat)
    );

    hqm_aw_sync_deglitch #(.FILTER_CYCLES(1), .RST_VAL(1'b0), .CNT_WIDTH(2)) u_dut_b (
        .clk          (clk),
        .rst_n        (b_rst_n),
        .data_sync    (b_ds),
        .enable       (b_en),
        .cnt_clr      (b_clr),
        .data_filt    (b_filt),
        .rise         (b_rise),
        .fall         (b_fall),
        .edge_cnt     (b_cnt),
        .edge_cnt_sat (b_sat)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic       ds;
        logic       filt;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic       sat;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rst_n, input logic en, input logic clr, input logic ds,
                       input logic filt, input logic rise, input logic fall,
                       input logic [7:0] cnt, input logic sat);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.clr = clr; v.ds = ds;
        v.filt = filt; v.rise = rise; v.fall = fall; v.cnt = cnt; v.sat = sat;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_ds = 1'b1; a_en = 1'b1; a_clr = 1'b0;
        b_rst_n = 1'b0; b_ds = 1'b0; b_en = 1'b1; b_clr = 1'b0;

        // rst_n en clr ds | filt rise fall cnt sat
        // Reset with data_sync=1, then release: rise on 4th edge, none at release.
        add(0,1,0,1, 0,0,0,0,0);
        add(0,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 1,1,0,1,0);
        add(1,1,0,1, 1,0,0,1,0);
        // Clean fall after 4 low samples
        add(1,1,0,0, 1,0,0,1,0);
        add(1,1,0,0, 1,0,0,1,0);
        add(1,1,0,0, 1,0,0,1,0);
        add(1,1,0,0, 0,0,1,2,0);
        add(1,1,0,0, 0,0,0,2,0);
        // Clean rise after 4 high samples
        add(1,1,0,1, 0,0,0,2,0);
        add(1,1,0,1, 0,0,0,2,0);
        add(1,1,0,1, 0,0,0,2,0);
        add(1,1,0,1, 1,1,0,3,0);
        add(1,1,0,1, 1,0,0,3,0);
        // 2 of 4 stable cycles, enable off 2 cycles, then 4 more needed
        add(1,1,0,0, 1,0,0,3,0);
        add(1,1,0,0, 1,0,0,3,0);
        add(1,0,0,0, 1,0,0,3,0);
        add(1,0,0,0, 1,0,0,3,0);
        add(1,1,0,0, 1,0,0,3,0);
        add(1,1,0,0, 1,0,0,3,0);
        add(1,1,0,0, 1,0,0,3,0);
        add(1,1,0,0, 0,0,1,4,0);
        // cnt_clr coincident with accepted rise -> count 1
        add(1,1,0,1, 0,0,0,4,0);
        add(1,1,0,1, 0,0,0,4,0);
        add(1,1,0,1, 0,0,0,4,0);
        add(1,1,1,1, 1,1,0,1,0);
        add(1,1,0,1, 1,0,0,1,0);
        // Plain clear
        add(1,1,1,1, 1,0,0,0,0);
        add(1,1,0,1, 1,0,0,0,0);
        // Fall, then reset mid-filter discards 2 cycles of rise progress
        add(1,1,0,0, 1,0,0,0,0);
        add(1,1,0,0, 1,0,0,0,0);
        add(1,1,0,0, 1,0,0,0,0);
        add(1,1,0,0, 0,0,1,1,0);
        add(1,1,0,1, 0,0,0,1,0);
        add(1,1,0,1, 0,0,0,1,0);
        add(0,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 1,1,0,1,0);
        add(1,1,0,1, 1,0,0,1,0);
        // Reset while filtered high: back to RST_VAL with no fall pulse
        add(0,1,0,1, 0,0,0,0,0);
        add(1,1,0,1, 0,0,0,0,0);

        foreach (vecs[i]) begin
            a_rst_n = vecs[i].rst_n;
            a_en    = vecs[i].en;
            a_clr   = vecs[i].clr;
            a_ds    = vecs[i].ds;
            step();
            chk($sformatf("vec%0d {filt,rise,fall,cnt,sat}", i),
                {20'd0, a_filt, a_rise, a_fall, a_cnt, a_sat},
                {20'd0, vecs[i].filt, vecs[i].rise, vecs[i].fall, vecs[i].cnt, vecs[i].sat});
        end

        // Glitches: 3 high then 1 low, 10 times, from a fresh reset
        a_rst_n = 1'b0; a_ds = 1'b0; a_en = 1'b1; a_clr = 1'b0;
        step();
        a_rst_n = 1'b1;
        for (int g = 0; g < 10; g++) begin
            for (int c = 0; c < 4; c++) begin
                a_ds = (c < 3);
                step();
                chk($sformatf("glitch%0d_%0d {filt,rise,fall,cnt}", g, c),
                    {21'd0, a_filt, a_rise, a_fall, a_cnt},
                    32'd0);
            end
        end

        // N=1, CNT_WIDTH=2: toggle every cycle, saturate, then clear
        b_rst_n = 1'b1;
        b_ds    = 1'b0;
        step();
        chk("n1_idle {filt,rise,fall,cnt,sat}", {26'd0, b_filt, b_rise, b_fall, b_cnt, b_sat}, 32'd0);
        for (int t = 1; t <= 6; t++) begin
            logic       ds_t;
            logic [1:0] cnt_t;
            ds_t  = (t % 2 == 1);
            cnt_t = (t >= 3) ? 2'd3 : 2'(t);
            b_ds  = ds_t;
            step();
            chk($sformatf("n1_toggle%0d {filt,rise,fall,cnt,sat}", t),
                {26'd0, b_filt, b_rise, b_fall, b_cnt, b_sat},
                {26'd0, ds_t, ds_t, ~ds_t, cnt_t, (t >= 3)});
        end
        // ds stays 0 (equal to filt) so the clear is not coincident with an edge
        b_clr = 1'b1;
        step();
        chk("n1_clr {filt,rise,fall,cnt,sat}", {26'd0, b_filt, b_rise, b_fall, b_cnt, b_sat}, 32'd0);
        b_clr = 1'b0;
        step();
        chk("n1_after_clr {cnt,sat}", {29'd0, b_cnt, b_sat}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
